// File: rtl/rom_arb_pkg.sv
// Shared types and defaults for the ROM burst arbiter.
package rom_arb_pkg;

  localparam int ADDR_W_DEF = 3;
  localparam int DATA_W_DEF = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  typedef logic port_id_t;

  localparam port_id_t PORT0 = 1'b0;
  localparam port_id_t PORT1 = 1'b1;

endpackage

// File: rtl/rom_arb_rr.sv
// Two-way request arbiter: round-robin on a last-grant pointer when
// ROM_ARB_RR_EN is defined, otherwise fixed priority with port 0 winning.
module rom_arb_rr
  import rom_arb_pkg::*;
(
`ifdef ROM_ARB_RR_EN
  input  logic     clk,
  input  logic     rst,
  input  logic     take,
`endif
  input  logic     req0,
  input  logic     req1,
  output logic     win_valid,
  output port_id_t win_id
);

  assign win_valid = req0 | req1;

`ifdef ROM_ARB_RR_EN
  port_id_t last_id;

  // Reset to port 1 so the first tie after reset goes to port 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_id <= PORT1;
    end else if (take) begin
      last_id <= win_id;
    end
  end

  always_comb begin
    win_id = PORT0;
    if (req0 && req1) begin
      win_id = (last_id == PORT0) ? PORT1 : PORT0;
    end else if (req1) begin
      win_id = PORT1;
    end
  end
`else
  assign win_id = (!req0 && req1) ? PORT1 : PORT0;
`endif

endmodule

// File: rtl/rom_burst_arbiter.sv
// Arbitrates two burst readers onto a combinational ROM and returns registered
// words tagged with the owning port. Round-robin when ROM_ARB_RR_EN is defined.
//
// state | meaning
// IDLE  | no burst; sample req0/req1 and grant a winner
// BURST | one ROM address issued per cycle until the remaining count hits zero
module rom_burst_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] len0,
  input  logic [ADDR_W-1:0] len1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_rd_en,
  output logic              rom_cs,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_last,
  output port_id_t          rd_id,
  output logic              busy
);

  state_t            state;
  logic [ADDR_W-1:0] words_left;
  port_id_t          owner;
  logic              win_valid;
  port_id_t          win_id;

`ifdef ROM_ARB_RR_EN
  logic arb_take;
  assign arb_take = (state == IDLE) && win_valid;
`endif

  rom_arb_rr u_arb (
`ifdef ROM_ARB_RR_EN
    .clk       (clk),
    .rst       (rst),
    .take      (arb_take),
`endif
    .req0      (req0),
    .req1      (req1),
    .win_valid (win_valid),
    .win_id    (win_id)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      words_left <= '0;
      owner      <= PORT0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      rom_addr   <= '0;
      rom_rd_en  <= 1'b0;
      rom_cs     <= 1'b0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
      rd_id      <= PORT0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;

      // Whatever was addressed this cycle becomes the next registered word.
      rd_valid <= rom_cs;
      rd_data  <= rom_cs ? rom_data : '0;
      rd_last  <= rom_cs && (words_left == '0);
      rd_id    <= rom_cs ? owner : PORT0;

      case (state)
        IDLE: begin
          if (win_valid) begin
            state      <= BURST;
            owner      <= win_id;
            gnt0       <= (win_id == PORT0);
            gnt1       <= (win_id == PORT1);
            rom_addr   <= (win_id == PORT1) ? addr1 : addr0;
            words_left <= (win_id == PORT1) ? len1 : len0;
            rom_cs     <= 1'b1;
            rom_rd_en  <= 1'b1;
          end
        end
        BURST: begin
          if (words_left == '0) begin
            state     <= IDLE;
            rom_addr  <= '0;
            rom_cs    <= 1'b0;
            rom_rd_en <= 1'b0;
          end else begin
            rom_addr   <= rom_addr + ADDR_W'(1);
            words_left <= words_left - ADDR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Randomized bench for rom_burst_arbiter against a timeline model of the burst
// protocol; the tie-break expectation follows ROM_ARB_RR_EN.
module tb_rom_burst_arbiter;
  import rom_arb_pkg::*;

  localparam int AW = 3;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1;
  logic [AW-1:0] addr0, addr1, len0, len1;
  logic          gnt0, gnt1;
  logic [AW-1:0] rom_addr;
  logic          rom_rd_en, rom_cs;
  logic [DW-1:0] rom_data, rd_data;
  logic          rd_valid, rd_last, busy;
  port_id_t      rd_id;

  logic [DW-1:0] rom [0:7];
  int            n_checks = 0;
  int            n_fail = 0;
  logic          mdl_last;
  int            waited;
  logic          exp_win;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  rom_burst_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .req1      (req1),
    .addr0     (addr0),
    .addr1     (addr1),
    .len0      (len0),
    .len1      (len1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .rom_addr  (rom_addr),
    .rom_rd_en (rom_rd_en),
    .rom_cs    (rom_cs),
    .rom_data  (rom_data),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_last   (rd_last),
    .rd_id     (rd_id),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] word_at(input int a, input int i);
    return rom[3'((a + i) % 8)];
  endfunction

  task automatic check_all_zero(input string tag);
    chk(tag, {gnt0, gnt1, rom_addr, rom_rd_en, rom_cs, rd_data, rd_valid, rd_last, rd_id, busy}, 0);
  endtask

  // Single burst from an idle DUT: grant one cycle after the sampling edge,
  // len+1 consecutive words starting the cycle after that.
  task automatic run_burst(input int p, input int a, input int l);
    @(negedge clk);
    if (p == 0) begin req0 = 1'b1; addr0 = 3'(a); len0 = 3'(l); end
    else        begin req1 = 1'b1; addr1 = 3'(a); len1 = 3'(l); end
    @(negedge clk);
    chk("gnt0", gnt0, p == 0);
    chk("gnt1", gnt1, p == 1);
    chk("busy_on", busy, 1);
    chk("cs_on", {rom_cs, rom_rd_en}, 3);
    chk("first_addr", rom_addr, a);
    req0 = 1'b0;
    req1 = 1'b0;
    mdl_last = p[0];
    for (int i = 0; i <= l; i++) begin
      @(negedge clk);
      chk("valid", rd_valid, 1);
      chk("data", rd_data, word_at(a, i));
      chk("last", rd_last, i == l);
      chk("id", rd_id, p);
    end
    chk("busy_end", busy, 0);
    @(negedge clk);
    chk("valid_after", rd_valid, 0);
    chk("idle_rom", {rom_cs, rom_rd_en, rom_addr}, 0);
  endtask

  task automatic run_back_to_back(input int a0, input int l0, input int a1, input int l1);
    @(negedge clk);
    req0 = 1'b1; addr0 = 3'(a0); len0 = 3'(l0);
    @(negedge clk);
    chk("b2b_gnt0", gnt0, 1);
    req0 = 1'b0;
    req1 = 1'b1; addr1 = 3'(a1); len1 = 3'(l1);
    for (int t = 1; t <= l0 + l1 + 5; t++) begin
      @(negedge clk);
      chk("b2b_gnt1", gnt1, t == l0 + 2);
      chk("b2b_gnt0_quiet", gnt0, 0);
      if (t <= l0 + 1) begin
        chk("b2b_valid0", rd_valid, 1);
        chk("b2b_data0", rd_data, word_at(a0, t - 1));
        chk("b2b_last0", rd_last, t == l0 + 1);
        chk("b2b_id0", rd_id, 0);
      end else if (t >= l0 + 3 && t <= l0 + 3 + l1) begin
        chk("b2b_valid1", rd_valid, 1);
        chk("b2b_data1", rd_data, word_at(a1, t - l0 - 3));
        chk("b2b_last1", rd_last, t == l0 + 3 + l1);
        chk("b2b_id1", rd_id, 1);
      end else begin
        chk("b2b_gap", rd_valid, 0);
      end
      if (t == l0 + 2) req1 = 1'b0;
    end
    mdl_last = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rom[0] = 8'd22; rom[1] = 8'd45;  rom[2] = 8'd60;  rom[3] = 8'd89;
    rom[4] = 8'd13; rom[5] = 8'd109; rom[6] = 8'd112; rom[7] = 8'd22;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    addr0 = '0; addr1 = '0; len0 = '0; len1 = '0;
    mdl_last = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");
    rst = 1'b0;

    run_burst(0, 2, 2);
    run_burst(1, 6, 3);
    for (int n = 0; n < 6; n++) begin
      run_burst(int'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    end

    // Both requesters held high with single-word bursts.
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b1;
    addr0 = 3'($urandom_range(0, 7)); addr1 = 3'($urandom_range(0, 7));
    len0 = '0; len1 = '0;
    for (int k = 0; k < 4; k++) begin
`ifdef ROM_ARB_RR_EN
      exp_win = ~mdl_last;
`else
      exp_win = 1'b0;
`endif
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (!(gnt0 || gnt1) && waited < 8);
      chk("arb_gnt_seen", gnt0 | gnt1, 1);
      chk("arb_onehot", gnt0 & gnt1, 0);
      chk("arb_winner", gnt1, exp_win);
      chk("arb_spacing", waited, (k == 0) ? 1 : 2);
      mdl_last = exp_win;
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (4) @(negedge clk);
    chk("arb_drained", busy, 0);

    // Reset on the second word of an 8-word burst.
    addr0 = 3'($urandom_range(0, 7));
    len0 = 3'd7;
    req0 = 1'b1;
    @(negedge clk);
    chk("rst_gnt0", gnt0, 1);
    req0 = 1'b0;
    @(negedge clk);
    chk("rst_valid1", rd_valid, 1);
    @(negedge clk);
    chk("rst_valid2", rd_valid, 1);
    chk("rst_data2", rd_data, word_at(int'(addr0), 1));
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("rst_mid_burst");
    rst = 1'b0;
    mdl_last = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("post_rst_no_valid", rd_valid, 0);
      chk("post_rst_idle", busy, 0);
    end

    // First tie after reset favours port 0 in either arbitration mode.
    req0 = 1'b1; req1 = 1'b1; len0 = '0; len1 = '0;
    @(negedge clk);
    chk("post_rst_tie_gnt0", gnt0, 1);
    chk("post_rst_tie_gnt1", gnt1, 0);
    req0 = 1'b0; req1 = 1'b0;
    mdl_last = 1'b0;
    repeat (3) @(negedge clk);

    run_back_to_back(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    run_back_to_back(5, 7, 7, 1);
    run_burst(0, int'($urandom_range(0, 7)), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
